// File: rtl/qbu_rx_pkg.sv
// Shared definitions for the qbu_rx frame dispatch path: SMD/CRC codes,
// channel indices, user-field layout, FSM encoding and the route decoder.
package qbu_rx_pkg;

  localparam logic [7:0] SMD_E = 8'hD5;
  localparam logic [7:0] SMD_R = 8'h19;
  localparam logic [7:0] SMD_V = 8'h07;
  localparam logic [7:0] S0    = 8'hE6;
  localparam logic [7:0] S1    = 8'h4C;
  localparam logic [7:0] S2    = 8'h7F;
  localparam logic [7:0] S3    = 8'hB3;
  localparam logic [7:0] C0    = 8'h61;
  localparam logic [7:0] C1    = 8'h52;
  localparam logic [7:0] C2    = 8'h9E;
  localparam logic [7:0] C3    = 8'h2A;

  localparam logic [1:0] CRC  = 2'b01;
  localparam logic [1:0] MCRC = 2'b10;

  localparam int NCH = 4;
  localparam logic [1:0] CH_EMAC = 2'd0;
  localparam logic [1:0] CH_PMAC = 2'd1;
  localparam logic [1:0] CH_R    = 2'd2;
  localparam logic [1:0] CH_V    = 2'd3;

  localparam int USER_W     = 16;
  localparam int U_INFO_VLD = 15;
  localparam int U_SMD_LSB  = 7;
  localparam int U_FRAG_LSB = 5;
  localparam int U_CRC_LSB  = 3;
  localparam int U_ERR      = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  typedef struct packed {
    logic       drop;
    logic       err;
    logic [1:0] ch;
  } route_t;

  // EMAC/R/V with a bad CRC code survive only when err_fwd is set, flagged as errored.
  function automatic route_t decode_route(input logic [USER_W-1:0] user, input logic err_fwd);
    route_t     r;
    logic [7:0] smd;
    logic [1:0] crc;
    logic       crc_ok;
    r      = '{drop: 1'b1, err: 1'b0, ch: CH_EMAC};
    smd    = user[U_SMD_LSB +: 8];
    crc    = user[U_CRC_LSB +: 2];
    crc_ok = (crc == CRC);
    if (user[U_INFO_VLD]) begin
      case (smd)
        SMD_E: begin r.ch = CH_EMAC; r.drop = !(crc_ok || err_fwd); r.err = !crc_ok; end
        SMD_R: begin r.ch = CH_R;    r.drop = !(crc_ok || err_fwd); r.err = !crc_ok; end
        SMD_V: begin r.ch = CH_V;    r.drop = !(crc_ok || err_fwd); r.err = !crc_ok; end
        S0, S1, S2, S3, C0, C1, C2, C3: begin
          r.ch   = CH_PMAC;
          r.drop = !(crc_ok || (crc == MCRC));
        end
        default: r.drop = 1'b1;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/qbu_rx_out_slice.sv
// One-stage AXIS register slice: one cycle of latency, full throughput,
// payload cleared whenever the slice is empty.
module qbu_rx_out_slice #(
  parameter int DWIDTH = 8,
  parameter int UWIDTH = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [DWIDTH-1:0]   i_s_data,
  input  logic [UWIDTH-1:0]   i_s_user,
  input  logic [DWIDTH/8-1:0] i_s_keep,
  input  logic                i_s_last,
  input  logic                i_s_valid,
  output logic                o_s_ready,
  output logic [DWIDTH-1:0]   o_m_data,
  output logic [UWIDTH-1:0]   o_m_user,
  output logic [DWIDTH/8-1:0] o_m_keep,
  output logic                o_m_last,
  output logic                o_m_valid,
  input  logic                i_m_ready
);

  logic                vld_p1;
  logic [DWIDTH-1:0]   data_p1;
  logic [UWIDTH-1:0]   user_p1;
  logic [DWIDTH/8-1:0] keep_p1;
  logic                last_p1;

  assign o_s_ready = !vld_p1 | i_m_ready;

  // Stage p1: output register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      user_p1 <= '0;
      keep_p1 <= '0;
      last_p1 <= 1'b0;
    end else if (i_s_valid && o_s_ready) begin
      vld_p1  <= 1'b1;
      data_p1 <= i_s_data;
      user_p1 <= i_s_user;
      keep_p1 <= i_s_keep;
      last_p1 <= i_s_last;
    end else if (i_m_ready) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      user_p1 <= '0;
      keep_p1 <= '0;
      last_p1 <= 1'b0;
    end
  end

  assign o_m_valid = vld_p1;
  assign o_m_data  = data_p1;
  assign o_m_user  = user_p1;
  assign o_m_keep  = keep_p1;
  assign o_m_last  = last_p1;

endmodule

// File: rtl/qbu_rx_frame_dispatch.sv
// Routes reassembled qbu_rx frames to EMAC/PMAC/R/V consumers by SMD/CRC,
// decided once on the first beat; unroutable frames are drained and counted.
module qbu_rx_frame_dispatch
  import qbu_rx_pkg::*;
#(
  parameter int DWIDTH  = 8,
  parameter int LEN_W   = 12,
  parameter int CNT_W   = 16,
  parameter bit ERR_FWD = 1'b0
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [DWIDTH-1:0]         i_s_axis_data,
  input  logic [15:0]               i_s_axis_user,
  input  logic [DWIDTH/8-1:0]       i_s_axis_keep,
  input  logic                      i_s_axis_last,
  input  logic                      i_s_axis_valid,
  output logic                      o_s_axis_ready,
  input  logic [LEN_W-1:0]          i_data_len,
  output logic [4*DWIDTH-1:0]       o_m_axis_data,
  output logic [4*16-1:0]           o_m_axis_user,
  output logic [4*(DWIDTH/8)-1:0]   o_m_axis_keep,
  output logic [3:0]                o_m_axis_last,
  output logic [3:0]                o_m_axis_valid,
  input  logic [3:0]                i_m_axis_ready,
  output logic [4*CNT_W-1:0]        o_fwd_cnt,
  output logic [CNT_W-1:0]          o_drop_cnt,
  output logic                      o_drop_pulse
);

  localparam int KW = DWIDTH / 8;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  state_e            state;
  logic [1:0]        ch_q;
  logic [USER_W-1:0] user_q;
  logic              pass_q;
  logic [CNT_W-1:0]  fwd_cnt [NCH];

  route_t            dec;
  logic [11:0]       len12;
  logic [1:0]        cur_ch;
  logic              fwd_sel;
  logic [USER_W-1:0] cur_user;
  logic              rdy;
  logic [NCH-1:0]    slice_rdy;
  logic [NCH-1:0]    slice_vld_in;
  logic              acc;
  logic              last_acc;

  assign dec   = decode_route(i_s_axis_user, ERR_FWD);
  assign len12 = 12'(i_data_len);

  // Stage p0: route selection and input handshake
  always_comb begin
    cur_ch   = ch_q;
    fwd_sel  = 1'b0;
    cur_user = user_q;
    rdy      = 1'b0;
    case (state)
      ST_IDLE: begin
        cur_ch   = dec.ch;
        fwd_sel  = !dec.drop;
        cur_user = (dec.ch == CH_PMAC) ? i_s_axis_user : {dec.err, 3'b000, len12};
        rdy      = dec.drop | slice_rdy[dec.ch];
      end
      ST_FWD: begin
        fwd_sel  = 1'b1;
        cur_user = pass_q ? i_s_axis_user : user_q;
        rdy      = slice_rdy[ch_q];
      end
      ST_DROP: rdy = 1'b1;
      default: rdy = 1'b0;
    endcase
  end

  assign o_s_axis_ready = rdy & !i_rst;
  assign acc            = i_s_axis_valid & o_s_axis_ready;
  assign last_acc       = acc & i_s_axis_last;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= ST_IDLE;
      ch_q         <= CH_EMAC;
      user_q       <= '0;
      pass_q       <= 1'b0;
      o_drop_cnt   <= '0;
      o_drop_pulse <= 1'b0;
      for (int c = 0; c < NCH; c++) fwd_cnt[c] <= '0;
    end else begin
      o_drop_pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (acc) begin
            ch_q   <= dec.ch;
            user_q <= cur_user;
            pass_q <= (dec.ch == CH_PMAC);
            if (!i_s_axis_last) state <= dec.drop ? ST_DROP : ST_FWD;
          end
        end
        ST_FWD, ST_DROP: begin
          if (last_acc) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
      if (last_acc && fwd_sel) fwd_cnt[cur_ch] <= sat_inc(fwd_cnt[cur_ch]);
      if (last_acc && !fwd_sel) begin
        o_drop_cnt   <= sat_inc(o_drop_cnt);
        o_drop_pulse <= 1'b1;
      end
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    assign slice_vld_in[c] = acc & fwd_sel & (cur_ch == 2'(c));

    qbu_rx_out_slice #(
      .DWIDTH(DWIDTH),
      .UWIDTH(USER_W)
    ) u_slice (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_s_data (i_s_axis_data),
      .i_s_user (cur_user),
      .i_s_keep (i_s_axis_keep),
      .i_s_last (i_s_axis_last),
      .i_s_valid(slice_vld_in[c]),
      .o_s_ready(slice_rdy[c]),
      .o_m_data (o_m_axis_data[c*DWIDTH +: DWIDTH]),
      .o_m_user (o_m_axis_user[c*USER_W +: USER_W]),
      .o_m_keep (o_m_axis_keep[c*KW +: KW]),
      .o_m_last (o_m_axis_last[c]),
      .o_m_valid(o_m_axis_valid[c]),
      .i_m_ready(i_m_axis_ready[c])
    );

    assign o_fwd_cnt[c*CNT_W +: CNT_W] = fwd_cnt[c];
  end

endmodule

// File: tb/tb_qbu_rx_frame_dispatch.sv
// Directed bench for qbu_rx_frame_dispatch: dut_a (ERR_FWD=0, 4-bit counters)
// and dut_b (ERR_FWD=1) share the input stream.
module tb_qbu_rx_frame_dispatch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  s_data = '0;
  logic [15:0] s_user = '0;
  logic        s_keep = 1'b0;
  logic        s_last = 1'b0;
  logic        s_valid = 1'b0;
  logic [11:0] s_len = '0;
  logic [3:0]  m_ready = 4'hF;

  logic        s_ready, s_ready_b;
  logic [31:0] m_data, m_data_b;
  logic [63:0] m_user, m_user_b;
  logic [3:0]  m_keep, m_keep_b, m_last, m_last_b, m_valid, m_valid_b;
  logic [15:0] fwd_a;
  logic [63:0] fwd_b;
  logic [3:0]  drop_a;
  logic [15:0] drop_b;
  logic        pulse_a, pulse_b;

  int total = 0;
  int bad   = 0;
  int dirty = 0;
  int pulses = 0;
  int trk_err = 0;
  bit trk_en = 0;
  bit tog_en = 0;
  logic [27:0] exp_q[$], obs_q[$], exp_b[$], obs_b[$];

  qbu_rx_frame_dispatch #(.DWIDTH(8), .LEN_W(12), .CNT_W(4), .ERR_FWD(1'b0)) dut_a (
    .i_clk(clk), .i_rst(rst),
    .i_s_axis_data(s_data), .i_s_axis_user(s_user), .i_s_axis_keep(s_keep),
    .i_s_axis_last(s_last), .i_s_axis_valid(s_valid), .o_s_axis_ready(s_ready),
    .i_data_len(s_len),
    .o_m_axis_data(m_data), .o_m_axis_user(m_user), .o_m_axis_keep(m_keep),
    .o_m_axis_last(m_last), .o_m_axis_valid(m_valid), .i_m_axis_ready(m_ready),
    .o_fwd_cnt(fwd_a), .o_drop_cnt(drop_a), .o_drop_pulse(pulse_a)
  );

  qbu_rx_frame_dispatch #(.DWIDTH(8), .LEN_W(12), .CNT_W(16), .ERR_FWD(1'b1)) dut_b (
    .i_clk(clk), .i_rst(rst),
    .i_s_axis_data(s_data), .i_s_axis_user(s_user), .i_s_axis_keep(s_keep),
    .i_s_axis_last(s_last), .i_s_axis_valid(s_valid), .o_s_axis_ready(s_ready_b),
    .i_data_len(s_len),
    .o_m_axis_data(m_data_b), .o_m_axis_user(m_user_b), .o_m_axis_keep(m_keep_b),
    .o_m_axis_last(m_last_b), .o_m_axis_valid(m_valid_b), .i_m_axis_ready(m_ready),
    .o_fwd_cnt(fwd_b), .o_drop_cnt(drop_b), .o_drop_pulse(pulse_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int c = 0; c < 4; c++) begin
        if (m_valid[c] && m_ready[c])
          obs_q.push_back({2'(c), m_last[c], m_keep[c], m_user[c*16 +: 16], m_data[c*8 +: 8]});
        else if (!m_valid[c] && (m_data[c*8 +: 8] != 0 || m_user[c*16 +: 16] != 0 || m_keep[c] || m_last[c]))
          dirty++;
      end
      if (m_valid_b[2] && m_ready[2])
        obs_b.push_back({2'd2, m_last_b[2], m_keep_b[2], m_user_b[32 +: 16], m_data_b[16 +: 8]});
      if (pulse_a) pulses++;
      if (trk_en && (s_ready !== (!m_valid[1] | m_ready[1]))) trk_err++;
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (tog_en) m_ready[1] = ~m_ready[1];
    end
  end

  task automatic send_beat(input logic [7:0] d, input logic k, input logic l, output int stalls);
    logic ok;
    s_data = d; s_keep = k; s_last = l; s_valid = 1'b1;
    ok = 1'b0;
    stalls = 0;
    while (!ok) begin
      @(negedge clk);
      ok = s_ready;
      @(posedge clk); #1;
      if (!ok) begin
        stalls++;
        if (stalls >= 100) begin
          chk("beat_accept", ok, 1'b1);
          break;
        end
      end
    end
  endtask

  task automatic send_frame(input logic [15:0] user, input logic [11:0] len, input int n,
                            input logic [7:0] base, input int ch, input logic [15:0] eu,
                            input int keep0, output int stalls);
    int st;
    logic [7:0] d;
    logic k, l;
    stalls = 0;
    s_user = user;
    s_len  = len;
    for (int i = 0; i < n; i++) begin
      d = base + 8'(i);
      k = (i == keep0) ? 1'b0 : 1'b1;
      l = (i == n - 1);
      if (ch >= 0) exp_q.push_back({2'(ch), l, k, eu, d});
      send_beat(d, k, l, st);
      stalls += st;
    end
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    s_last  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cmp_q(input string tag);
    chk({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk($sformatf("%s_beat%0d", tag, i), 64'(obs_q[i]), 64'(exp_q[i]));
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int st;
    // reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", s_ready, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_valid", m_valid, 4'h0);
    chk("rst_fwd", fwd_a, 16'h0);
    chk("rst_drop", drop_a, 4'h0);
    chk("rst_pulse", pulse_a, 1'b0);

    // EMAC 64 beats, user = {0,000,len}
    s_user = 16'hEA88; s_len = 12'd64;
    exp_q.push_back({2'd0, 1'b0, 1'b1, 16'h0040, 8'h10});
    send_beat(8'h10, 1'b1, 1'b0, st);
    chk("emac_lat_valid", m_valid, 4'b0001);
    chk("emac_lat_data", m_data[7:0], 8'h10);
    chk("emac_lat_user", m_user[15:0], 16'h0040);
    for (int i = 1; i < 64; i++) begin
      exp_q.push_back({2'd0, (i == 63), 1'b1, 16'h0040, 8'h10 + 8'(i)});
      send_beat(8'h10 + 8'(i), 1'b1, (i == 63), st);
      chk("emac_stall", 64'(st), 64'd0);
    end
    idle(3);
    cmp_q("emac");
    chk("emac_fwd0", fwd_a[3:0], 4'd1);
    chk("emac_fwd_other", fwd_a[15:4], 12'h0);

    // PMAC fragment under toggling ready on ch1
    trk_en = 1; tog_en = 1;
    send_frame(16'hB0B0, 12'd10, 10, 8'h40, 1, 16'hB0B0, -1, st);
    idle(5);
    tog_en = 0; trk_en = 0;
    m_ready = 4'hF;
    cmp_q("pmac");
    chk("pmac_track", 64'(trk_err), 64'd0);
    chk("pmac_fwd1", fwd_a[7:4], 4'd1);

    // R frame with crc 11: dropped by dut_a, forwarded with err flag by dut_b
    pulses = 0;
    for (int i = 0; i < 5; i++)
      exp_b.push_back({2'd2, (i == 4), 1'b1, 16'h8005, 8'h80 + 8'(i)});
    send_frame(16'h8C98, 12'd5, 5, 8'h80, -1, 16'h0, -1, st);
    chk("rerr_stall", 64'(st), 64'd0);
    idle(3);
    cmp_q("rerr_a");
    chk("rerr_pulse", 64'(pulses), 64'd1);
    chk("rerr_drop", drop_a, 4'd1);
    chk("rerr_fwd2", fwd_a[11:8], 4'd0);
    chk("rerr_b_count", 64'(obs_b.size()), 64'(exp_b.size()));
    for (int i = 0; i < exp_b.size() && i < obs_b.size(); i++)
      chk($sformatf("rerr_b_beat%0d", i), 64'(obs_b[i]), 64'(exp_b[i]));
    chk("rerr_b_fwd2", fwd_b[47:32], 16'd1);

    // back-to-back V (keep=0 mid-frame) then single-beat EMAC
    send_frame(16'h8388, 12'd3, 3, 8'h20, 3, 16'h0003, 1, st);
    send_frame(16'hEA88, 12'd1, 1, 8'h30, 0, 16'h0001, -1, st);
    idle(3);
    cmp_q("b2b");
    chk("b2b_fwd3", fwd_a[15:12], 4'd1);
    chk("b2b_fwd0", fwd_a[3:0], 4'd2);

    // reset in the middle of a PMAC frame
    s_user = 16'hB0B0; s_len = 12'd10;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) exp_q.push_back({2'd1, 1'b0, 1'b1, 16'hB0B0, 8'h50 + 8'(i)});
      send_beat(8'h50 + 8'(i), 1'b1, 1'b0, st);
    end
    rst = 1'b1; s_valid = 1'b0;
    @(negedge clk);
    chk("mid_rst_ready", s_ready, 1'b0);
    @(posedge clk); #1;
    chk("mid_rst_valid", m_valid, 4'h0);
    chk("mid_rst_fwd", fwd_a, 16'h0);
    chk("mid_rst_drop", drop_a, 4'h0);
    rst = 1'b0;
    for (int i = 5; i < 10; i++) begin
      exp_q.push_back({2'd1, (i == 9), 1'b1, 16'hB0B0, 8'h50 + 8'(i)});
      send_beat(8'h50 + 8'(i), 1'b1, (i == 9), st);
    end
    idle(3);
    cmp_q("mid_rst");
    chk("mid_rst_fwd1", fwd_a[7:4], 4'd1);

    // drop counter saturation
    pulses = 0;
    for (int f = 0; f < 16; f++) begin
      send_frame((f % 2) ? 16'hB098 : 16'h6A88, 12'd2, (f % 2) + 1, 8'(f), -1, 16'h0, -1, st);
      chk($sformatf("sat_stall%0d", f), 64'(st), 64'd0);
      if (f == 14) begin
        idle(2);
        chk("sat_drop15", drop_a, 4'd15);
      end
    end
    idle(3);
    chk("sat_hold", drop_a, 4'd15);
    chk("sat_pulses", 64'(pulses), 64'd16);
    cmp_q("sat");
    chk("idle_payload_zero", 64'(dirty), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
